// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage iterative multiply/divide sequencer.
// Op encodings match the RV32M funct3 field.
package muldiv_pkg;

  localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_e;

  function automatic logic op_a_signed(input md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned shift-add multiplier / restoring divider, one bit per enabled step.
// Exposes the post-step values so the owner can capture the final result on the last step.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_op_x,
  input  logic [XLEN-1:0]   i_op_y,
  output logic [2*XLEN-1:0] o_acc_nxt,
  output logic [XLEN-1:0]   o_rem_nxt
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_opx;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN-1:0]   w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_rem_nxt;

  // Multiply keeps the partial product in the upper half and shifts the multiplier out of the lower half.
  assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opx} : {(XLEN+1){1'b0}});
  // Divide shifts the dividend MSB into the remainder; the low XLEN bits of the difference are exact when w_ge.
  assign w_shift = {r_rem, r_acc[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opx});
  assign w_diff  = w_shift[XLEN-1:0] - r_opx;

  always_comb begin
    w_acc_nxt = r_acc;
    w_rem_nxt = r_rem;
    if (i_is_div) begin
      w_acc_nxt = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_ge};
      w_rem_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
    end else begin
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_opx <= '0;
    end else if (i_load) begin
      r_acc <= {{XLEN{1'b0}}, i_op_y};
      r_rem <= '0;
      r_opx <= i_op_x;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  assign o_acc_nxt = w_acc_nxt;
  assign o_rem_nxt = w_rem_nxt;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage RV32M sequencer: stalls the pipeline while an M-op iterates, then presents the result.
// Division by zero and signed overflow bypass the iteration and complete on the next cycle.
module ex_muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_start,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            flush,
  input  logic            hold,
  output logic            md_stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       r_state;
  md_op_e          r_op;
  logic            r_neg;
  logic [CW-1:0]   r_count;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  md_op_e            w_op;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_is_div;
  logic              w_neg_start;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_fast_result;
  logic              w_accept;
  logic              w_step;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  assign w_op     = md_op_e'(md_funct3);
  assign w_is_div = md_funct3[2];
  assign w_sa     = op_a_signed(w_op) & md_a[XLEN-1];
  assign w_sb     = op_b_signed(w_op) & md_b[XLEN-1];
  assign w_abs_a  = w_sa ? (~md_a + 1'b1) : md_a;
  assign w_abs_b  = w_sb ? (~md_b + 1'b1) : md_b;

  // Remainder follows the dividend's sign; every other signed result is negative when exactly one operand is.
  assign w_neg_start = (w_op == OP_REM) ? w_sa : (w_sa ^ w_sb);

  assign w_div_zero    = w_is_div && (md_b == '0);
  assign w_ovf         = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                         (md_a == {1'b1, {(XLEN-1){1'b0}}}) && (md_b == '1);
  assign w_fast_result = w_div_zero ? (md_funct3[1] ? md_a : '1)
                                    : (md_funct3[1] ? '0 : md_a);

  assign w_accept = (r_state == IDLE) && md_start && !flush;
  assign w_step   = (r_state == CALC) && !flush;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_is_div  (r_op[2]),
    .i_op_x    (w_is_div ? w_abs_b : w_abs_a),
    .i_op_y    (w_is_div ? w_abs_a : w_abs_b),
    .o_acc_nxt (w_acc_nxt),
    .o_rem_nxt (w_rem_nxt)
  );

  assign w_prod_fix = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
  assign w_quot_fix = r_neg ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
  assign w_rem_fix  = r_neg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quot_fix;
      OP_REM, OP_REMU:              w_final = w_rem_fix;
      default:                      w_final = '0;
    endcase
  end

  assign md_stall = !flush && (((r_state == IDLE) && md_start) || (r_state == CALC));

  // Flush overrides everything, including a start in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (md_start) begin
            r_op  <= w_op;
            r_neg <= w_neg_start;
            if (w_div_zero || w_ovf) begin
              r_result <= w_fast_result;
              r_valid  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_count <= CW'(XLEN-1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (r_count == '0) begin
            r_result <= w_final;
            r_valid  <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        DONE: begin
          if (!hold) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign md_valid  = r_valid;
  assign md_result = r_result;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomized and directed bench for ex_muldiv_sequencer against a plain-arithmetic RV32M model.
// Checks results, latency, stall duration, flush, hold and mid-op reset behaviour.
module tb_ex_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            md_start;
  logic [2:0]      md_funct3;
  logic [XLEN-1:0] md_a;
  logic [XLEN-1:0] md_b;
  logic            flush;
  logic            hold;
  logic            md_stall;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start),
    .md_funct3 (md_funct3),
    .md_a      (md_a),
    .md_b      (md_b),
    .flush     (flush),
    .hold      (hold),
    .md_stall  (md_stall),
    .md_valid  (md_valid),
    .md_result (md_result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // RV32M semantics from 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ua, ub, q;
    longint unsigned uu;
    logic [63:0]     p;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (f)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin uu = longint'(ua) * longint'(ub); p = uu; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin q = sa / sb; p = q; r = p[31:0]; end
      end
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin q = sa % sb; p = q; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit isFast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 0) || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issues one op from IDLE with hold low; expects to be called at posedge+2.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int stallCnt;
    int expLat;
    expLat    = isFast(f, a, b) ? 1 : XLEN + 1;
    md_funct3 = f;
    md_a      = a;
    md_b      = b;
    md_start  = 1'b1;
    #1;
    stallCnt = md_stall ? 1 : 0;
    cyc      = 0;
    while (!md_valid && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
      if (!md_valid && md_stall) stallCnt++;
    end
    checkOutput({tag, "_lat"}, cyc, expLat);
    checkOutput({tag, "_res"}, md_result, refModel(f, a, b));
    checkOutput({tag, "_stallcnt"}, stallCnt, expLat);
    checkOutput({tag, "_stall_at_valid"}, {31'b0, md_stall}, 32'd0);
    md_start = 1'b0;
    @(posedge clk); #2;
    checkOutput({tag, "_idle_valid"}, {31'b0, md_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] heldResult;
    int          validSeen;
    rst_n     = 1'b0;
    md_start  = 1'b0;
    md_funct3 = 3'b000;
    md_a      = '0;
    md_b      = '0;
    flush     = 1'b0;
    hold      = 1'b0;
    #1;
    checkOutput("rst_valid", {31'b0, md_valid}, 32'd0);
    checkOutput("rst_stall", {31'b0, md_stall}, 32'd0);
    checkOutput("rst_result", md_result, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    applyStimulus("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mul_7_m3_const", md_result, 32'hFFFF_FFEB);
    applyStimulus("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000);
    checkOutput("mulh_min_const", md_result, 32'h4000_0000);
    applyStimulus("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("mulhu_max_const", md_result, 32'hFFFF_FFFE);
    applyStimulus("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002);
    applyStimulus("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_m7_2_const", md_result, 32'hFFFF_FFFD);
    applyStimulus("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    applyStimulus("divu_100_7", 3'b101, 32'd100, 32'd7);
    checkOutput("divu_100_7_const", md_result, 32'd14);
    applyStimulus("remu_100_7", 3'b111, 32'd100, 32'd7);
    applyStimulus("divu_by0", 3'b101, 32'd5, 32'd0);
    applyStimulus("rem_by0", 3'b110, 32'd5, 32'd0);
    checkOutput("rem_by0_const", md_result, 32'd5);
    applyStimulus("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      a = pickOperand();
      b = pickOperand();
      applyStimulus($sformatf("rnd%0d_f%0d", i, f), f, a, b);
    end

    // Flush ten cycles into an iterating multiply.
    md_funct3 = 3'b000;
    md_a      = 32'd1234;
    md_b      = 32'd5678;
    md_start  = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", {31'b0, md_stall}, 32'd0);
    @(posedge clk); #2;
    flush    = 1'b0;
    md_start = 1'b0;
    #1;
    checkOutput("flush_idle_stall", {31'b0, md_stall}, 32'd0);
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (md_valid) validSeen++;
    end
    checkOutput("flush_no_valid", validSeen, 32'd0);
    applyStimulus("after_flush", 3'b011, 32'hDEAD_BEEF, 32'h1234_5678);

    // Hold for three cycles in DONE, then release.
    hold      = 1'b1;
    md_funct3 = 3'b100;
    md_a      = 32'hFFFF_FC18;
    md_b      = 32'd7;
    md_start  = 1'b1;
    validSeen = 0;
    while (!md_valid && validSeen < 100) begin
      @(posedge clk); #2;
      validSeen++;
    end
    checkOutput("hold_lat", validSeen, XLEN + 1);
    heldResult = md_result;
    checkOutput("hold_res", heldResult, refModel(3'b100, 32'hFFFF_FC18, 32'd7));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #2;
      checkOutput($sformatf("hold_valid%0d", i), {31'b0, md_valid}, 32'd1);
      checkOutput($sformatf("hold_res%0d", i), md_result, heldResult);
      if (i == 3) begin
        hold     = 1'b0;
        md_start = 1'b0;
      end
    end
    @(posedge clk); #2;
    checkOutput("hold_release", {31'b0, md_valid}, 32'd0);

    // Reset pulse in the middle of a divide.
    md_funct3 = 3'b101;
    md_a      = 32'd100;
    md_b      = 32'd7;
    md_start  = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    md_start = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, md_valid}, 32'd0);
    checkOutput("midrst_stall", {31'b0, md_stall}, 32'd0);
    checkOutput("midrst_result", md_result, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    applyStimulus("after_rst", 3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
